// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: state encodings, skip opcodes and widths.
package fetch_sequencer_pkg;

  localparam int unsigned PC_W    = 8;
  localparam int unsigned INSTR_W = 8;

  localparam logic [3:0] OP_SNZA = 4'd8;
  localparam logic [3:0] OP_SNZS = 4'd9;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    FETCH   = 2'b01,
    DECODE  = 2'b10,
    EXECUTE = 2'b11
  } state_t;

  // True when the executing instruction arms a skip of the next one.
  function automatic logic skip_taken(input logic [3:0] op,
                                      input logic       a_nz,
                                      input logic       s_nz);
    return ((op == OP_SNZA) && a_nz) || ((op == OP_SNZS) && s_nz);
  endfunction

endpackage

// File: rtl/fetch_sequencer_program_counter.sv
// Program counter: PC_W-bit register, increments (wrapping) when i_inc is high.
module program_counter
  import fetch_sequencer_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_inc,
  output logic [PC_W-1:0] o_pc
);

  logic [PC_W-1:0] r_pc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc <= '0;
    end else if (i_inc) begin
      r_pc <= r_pc + 1'b1;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/decode/execute sequencer with run/step control and SNZA/SNZS skip handling.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               step,
  output logic               mem_req,
  output logic [PC_W-1:0]    mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               a_nz,
  input  logic               s_nz,
  output logic [3:0]         opcode,
  output logic [3:0]         operand,
  output logic               exec_en,
  output logic [PC_W-1:0]    pc,
  output logic               busy
);

  state_t             r_state;
  logic [INSTR_W-1:0] r_ir;
  logic               r_skip;
  logic               r_mem_req;
  logic               r_exec_en;
  logic               r_busy;
  logic               w_fetch_done;
  logic [PC_W-1:0]    w_pc;

  // Ack only counts while a request is outstanding.
  assign w_fetch_done = r_mem_req & mem_ack;

  program_counter u_pc (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_inc   (w_fetch_done),
    .o_pc    (w_pc)
  );

  // Outputs are registered alongside the state, so each branch sets them for the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_ir      <= '0;
      r_skip    <= 1'b0;
      r_mem_req <= 1'b0;
      r_exec_en <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (run || step) begin
            r_state   <= FETCH;
            r_mem_req <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        FETCH: begin
          if (w_fetch_done) begin
            r_ir      <= mem_rdata;
            r_state   <= DECODE;
            r_mem_req <= 1'b0;
          end
        end
        DECODE: begin
          if (r_skip) begin
            r_skip <= 1'b0;
            if (run) begin
              r_state   <= FETCH;
              r_mem_req <= 1'b1;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_state   <= EXECUTE;
            r_exec_en <= 1'b1;
          end
        end
        EXECUTE: begin
          r_exec_en <= 1'b0;
          if (skip_taken(r_ir[7:4], a_nz, s_nz)) begin
            r_skip <= 1'b1;
          end
          if (run) begin
            r_state   <= FETCH;
            r_mem_req <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_mem_req <= 1'b0;
          r_exec_en <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req  = r_mem_req;
  assign mem_addr = w_pc;
  assign pc       = w_pc;
  assign opcode   = r_ir[7:4];
  assign operand  = r_ir[3:0];
  assign exec_en  = r_exec_en;
  assign busy     = r_busy;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: ROM model with programmable ack latency.
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       reset, run, step, a_nz, s_nz;
  logic       mem_req, mem_ack, exec_en, busy;
  logic [7:0] mem_addr, mem_rdata, pc;
  logic [3:0] opcode, operand;

  logic [7:0] rom [256];
  logic       ack_en    = 1'b1;
  logic       force_ack = 1'b0;
  int         ack_delay = 0;
  int         wcnt      = 0;
  int         exec_cnt  = 0;
  int         req_cnt   = 0;
  logic [3:0] last_op   = '0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign mem_rdata = rom[mem_addr];
  assign mem_ack   = force_ack | (ack_en & mem_req & (wcnt >= ack_delay));

  always @(posedge clk) begin
    if (!mem_req || mem_ack) wcnt <= 0;
    else                     wcnt <= wcnt + 1;
    if (exec_en) begin
      exec_cnt <= exec_cnt + 1;
      last_op  <= opcode;
    end
    if (mem_req) req_cnt <= req_cnt + 1;
  end

  fetch_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .step      (step),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .a_nz      (a_nz),
    .s_nz      (s_nz),
    .opcode    (opcode),
    .operand   (operand),
    .exec_en   (exec_en),
    .pc        (pc),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    run   = 1'b0;
    step  = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(1);
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int k = 0;
    while (busy && k < bound) begin
      tick();
      k++;
    end
    check({tag, "_idle"}, busy, 0);
  endtask

  task automatic do_step(input int hold, output int delta);
    int e0 = exec_cnt;
    step = 1'b1;
    tick(hold);
    step = 1'b0;
    wait_idle("step", 20);
    delta = exec_cnt - e0;
  endtask

  initial begin
    int e0, r0, d, k;
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    reset = 1'b0; run = 1'b0; step = 1'b0; a_nz = 1'b0; s_nz = 1'b0;

    // Reset state, and no movement after release without run/step
    tick(2);
    check("rst_mem_req", mem_req, 0);
    check("rst_busy", busy, 0);
    check("rst_pc", pc, 0);
    check("rst_opcode", opcode, 0);
    check("rst_exec_en", exec_en, 0);
    reset = 1'b1;
    tick(3);
    check("post_rst_busy", busy, 0);
    check("post_rst_pc", pc, 0);

    // Same-cycle ack: FETCH, DECODE, EXECUTE, next FETCH in cycle 4
    rom[0] = 8'h15;
    apply_reset();
    run = 1'b1;
    tick();
    check("t1_c1_req", mem_req, 1);
    check("t1_c1_addr", mem_addr, 8'h00);
    tick();
    check("t1_c2_opcode", opcode, 4'd1);
    check("t1_c2_operand", operand, 4'd5);
    check("t1_c2_pc", pc, 8'h01);
    check("t1_c2_req", mem_req, 0);
    check("t1_c2_exec", exec_en, 0);
    tick();
    check("t1_c3_exec", exec_en, 1);
    tick();
    check("t1_c4_req", mem_req, 1);
    check("t1_c4_addr", mem_addr, 8'h01);
    run = 1'b0;
    wait_idle("t1", 20);
    check("t1_pc_end", pc, 8'h02);

    // Ack delayed 4 cycles, run dropped mid-instruction
    apply_reset();
    ack_delay = 4;
    e0 = exec_cnt; r0 = req_cnt;
    run = 1'b1;
    tick();
    check("t2_c1_req", mem_req, 1);
    run = 1'b0;
    tick(2);
    check("t2_c3_pc", pc, 8'h00);
    check("t2_c3_req", mem_req, 1);
    tick(2);
    check("t2_c5_pc", pc, 8'h00);
    tick();
    check("t2_c6_pc", pc, 8'h01);
    check("t2_c6_req", mem_req, 0);
    check("t2_c6_opcode", opcode, 4'd1);
    wait_idle("t2", 20);
    check("t2_exec_cnt", exec_cnt - e0, 1);
    check("t2_req_cycles", req_cnt - r0, 5);
    ack_delay = 0;

    // SNZA with a_nz=1: instruction at 1 skipped
    rom[0] = 8'h80; rom[1] = 8'h20; rom[2] = 8'h30;
    apply_reset();
    a_nz = 1'b1;
    e0 = exec_cnt;
    run = 1'b1;
    tick(4);
    check("t3_c4_addr", mem_addr, 8'h01);
    tick();
    check("t3_c5_opcode", opcode, 4'd2);
    check("t3_c5_exec", exec_en, 0);
    check("t3_c5_pc", pc, 8'h02);
    tick();
    check("t3_c6_req", mem_req, 1);
    check("t3_c6_addr", mem_addr, 8'h02);
    run = 1'b0;
    wait_idle("t3", 20);
    check("t3_exec_cnt", exec_cnt - e0, 2);
    check("t3_last_op", last_op, 4'd3);

    // Same program with a_nz=0: instruction at 1 executes
    apply_reset();
    a_nz = 1'b0;
    e0 = exec_cnt;
    run = 1'b1;
    tick(6);
    check("t4_c6_exec", exec_en, 1);
    check("t4_c6_opcode", opcode, 4'd2);
    run = 1'b0;
    wait_idle("t4", 20);
    check("t4_exec_cnt", exec_cnt - e0, 2);
    check("t4_pc", pc, 8'h02);

    // Step mode, SNZS, skip persisting across IDLE, step held during busy
    rom[0] = 8'h90; rom[1] = 8'h11; rom[2] = 8'h90; rom[3] = 8'h12; rom[4] = 8'h00;
    apply_reset();
    s_nz = 1'b1; a_nz = 1'b0;
    do_step(1, d);
    check("t5_step0_exec", d, 1);
    do_step(1, d);
    check("t5_step1_skipped", d, 0);
    check("t5_pc2", pc, 8'h02);
    s_nz = 1'b0; a_nz = 1'b1;
    do_step(1, d);
    check("t5_step2_exec", d, 1);
    do_step(1, d);
    check("t5_step3_exec", d, 1);
    check("t5_last_op", last_op, 4'd1);
    check("t5_pc4", pc, 8'h04);
    do_step(3, d);
    check("t5_hold_exec", d, 1);
    check("t5_hold_pc", pc, 8'h05);
    a_nz = 1'b0;

    // pc wrap from 8'hFF
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    apply_reset();
    run = 1'b1;
    for (k = 0; k < 2000 && !(mem_req && mem_addr == 8'hFF); k++) tick();
    check("t6_reach_ff", {mem_req, mem_addr}, {1'b1, 8'hFF});
    tick();
    check("t6_pc_wrap", pc, 8'h00);
    check("t6_decode_req", mem_req, 0);
    tick(2);
    check("t6_refetch_req", mem_req, 1);
    check("t6_refetch_addr", mem_addr, 8'h00);
    run = 1'b0;
    wait_idle("t6", 20);

    // Reset during a FETCH wait, late ack discarded
    rom[0] = 8'h15;
    apply_reset();
    ack_en = 1'b0;
    run = 1'b1;
    tick(3);
    check("t7_wait_req", mem_req, 1);
    e0 = exec_cnt;
    force_ack = 1'b1;
    reset = 1'b0;
    #1;
    check("t7_async_req", mem_req, 0);
    check("t7_async_busy", busy, 0);
    run = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(2);
    check("t7_pc", pc, 8'h00);
    check("t7_ir", {opcode, operand}, 8'h00);
    check("t7_busy", busy, 0);
    check("t7_exec_cnt", exec_cnt - e0, 0);
    force_ack = 1'b0;
    ack_en = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 clk  in  1  system clock; all state changes on its rising edge.
REQ-002 reset  in  1  asynchronous, active-low; 0 forces reset state immediately, independent of clk.
REQ-003 run  in  1  1 = fetch/execute continuously; 0 = stop at the next instruction boundary.
REQ-004 step  in  1  sampled only in IDLE with run=0; 1 = execute exactly one instruction, then return to IDLE.
REQ-005 mem_req  out  1  program-memory read request.
REQ-006 mem_addr  out  8  program-memory address; equals pc.
REQ-007 mem_ack  in  1  memory read-data-valid strobe; ignored when mem_req=0.
REQ-008 mem_rdata  in  8  instruction word: [7:4] opcode, [3:0] operand.
REQ-009 a_nz  in  1  datapath flag: register A non-zero.
REQ-010 s_nz  in  1  datapath flag: result S non-zero.
REQ-011 opcode  out  4  IR[7:4]; feeds the instruction decoder.
REQ-012 operand  out  4  IR[3:0]; immediate for the datapath.
REQ-013 exec_en  out  1  single-cycle strobe; the datapath commits the decoded instruction only when 1.
REQ-014 pc  out  8  program counter (address of the next fetch).
REQ-015 busy  out  1  1 in any state other than IDLE.

Function
REQ-016 FSM states: IDLE, FETCH, DECODE, EXECUTE; the state register shall be 2 bits wide.
REQ-017 IDLE: mem_req=0 and exec_en=0; if run=1 or step=1, the next state shall be FETCH, otherwise IDLE.
REQ-018 FETCH: mem_req=1 and mem_addr=pc; the state shall be held for any number of wait cycles until mem_ack=1.
REQ-019 FETCH with mem_ack=1: IR<=mem_rdata, pc<=pc+1 (modulo 256, 8'hFF wraps to 8'h00), next state DECODE; mem_req shall be 0 from the following cycle.
REQ-020 DECODE lasts one cycle with opcode/operand valid from IR and exec_en=0.
REQ-021 DECODE with skip_pending=0: the next state shall be EXECUTE.
REQ-022 DECODE with skip_pending=1: skip_pending shall clear, exec_en shall not pulse, and the next state shall be FETCH if run=1, otherwise IDLE.
REQ-023 EXECUTE lasts one cycle with exec_en=1; the next state shall be FETCH if run=1, otherwise IDLE.
REQ-024 In EXECUTE, opcode 4'd8 (SNZA) with a_nz=1, or opcode 4'd9 (SNZS) with s_nz=1, shall set skip_pending; flags shall be sampled in the EXECUTE cycle only.
REQ-025 All other opcodes shall not alter skip_pending or pc beyond the fetch increment.
REQ-026 Minimum latency shall be 3 cycles per executed instruction (FETCH with same-cycle ack, DECODE, EXECUTE) and 2 cycles per skipped instruction.
REQ-027 Deasserting run mid-instruction shall not abort the instruction; it shall complete and the FSM shall then enter IDLE.
REQ-028 A step shall fetch exactly one instruction; if that instruction is skipped, the step shall be consumed with no exec_en pulse.
REQ-029 step=1 while busy=1 shall be ignored.
REQ-030 opcode/operand shall change only on the mem_ack capture edge and shall stay stable through DECODE and EXECUTE.
REQ-031 skip_pending shall persist across IDLE (a skip armed before a stop applies to the next fetched instruction).

Reset
REQ-032 While reset=0: state=IDLE, pc=8'h00, IR=8'h00, skip_pending=0, and all outputs 0 (mem_req, exec_en, busy, opcode, operand, mem_addr).
REQ-033 Reset asserted during FETCH shall drop mem_req asynchronously; any mem_ack arriving during or after reset shall be discarded.
REQ-034 After reset release, no state change shall occur before the first clk edge with run=1 or step=1.

Structure
REQ-035 A shared package shall hold the state encodings (IDLE=2'b00, FETCH=2'b01, DECODE=2'b10, EXECUTE=2'b11), OP_SNZA=4'd8, OP_SNZS=4'd9, and the widths PC_W=8 and INSTR_W=8.
REQ-036 One sub-module, program_counter (8-bit register with increment-enable and asynchronous active-low reset), shall be instantiated; all other logic shall reside in fetch_sequencer.

Verification
REQ-037 Reset, run=1, ack same cycle, ROM[0]=8'h15 -> opcode=1, operand=5, exec_en high in cycle 3, pc=1; next mem_req in cycle 4.
REQ-038 mem_ack delayed 4 cycles -> mem_req held 5 cycles, pc unchanged until the ack edge, exactly one exec_en.
REQ-039 ROM[0]=8'h80 with a_nz=1 and ROM[1]=8'h20 -> the instruction at address 1 gets no exec_en, pc=2 after its fetch; the same sequence with a_nz=0 -> exec_en for address 1.
REQ-040 pc=8'hFF, fetch -> pc=8'h00, no stall.
REQ-041 run=0, step pulse -> exactly one exec_en, return to IDLE, busy=0; step held during busy -> no extra instruction.
REQ-042 reset=0 during FETCH wait, followed by a late mem_ack -> mem_req=0 immediately, pc=0, IR=0, no exec_en.
